multicycle_control_fsm: RTL

- Multi-cycle RV32I control sequencer: steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Drives the strobes and mux selects for the IR, PC, register file, ALU operand muxes and the immediate path.
- Handshakes with a single memory port.
- Traps permanently on an illegal opcode or a memory timeout.

---
 rtl/multicycle_control_fsm.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with a
// single memory port handshake, a retired-instruction counter and a sticky trap state.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [6:0]       r_opq;
  logic [TW-1:0]    r_tmo;
  logic [CNT_W-1:0] r_ret;
  logic             w_retire;

  function automatic logic f_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: f_legal = 1'b1;
      default:                           f_legal = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_opq   <= '0;
      r_tmo   <= '0;
      r_ret   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opq <= opcode;
      // Any state change restarts the wait count, which covers entry to FETCH and MEM
      if (w_next != r_state)          r_tmo <= '0;
      else if (mem_req && !mem_ready) r_tmo <= r_tmo + TW'(1);
      if (w_retire) r_ret <= r_ret + CNT_W'(1);
    end
  end

  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end else if (r_tmo == TMO_LAST) begin
          w_next = S_TRAP;
        end
      end
      S_DECODE: begin
        w_next = f_legal(opcode) ? S_EXECUTE : S_TRAP;
      end
      S_EXECUTE: begin
        w_next = S_WRITEBACK;
        case (r_opq)
          OP_R: alu_src_b = 1'b0;
          OP_LOAD, OP_STORE: begin
            alu_src_b = 1'b1;
            w_next    = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
            pc_write  = branch_taken;
            pc_sel    = branch_taken;
            w_next    = S_FETCH;
            w_retire  = 1'b1;
          end
          OP_AUIPC, OP_JAL: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
          end
          default: alu_src_b = 1'b1;
        endcase
      end
      S_MEM: begin
        mem_req   = 1'b1;
        alu_src_b = 1'b1;
        mem_we    = (r_opq == OP_STORE);
        if (mem_ready) begin
          if (r_opq == OP_STORE) begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end else begin
            w_next = S_WRITEBACK;
          end
        end else if (r_tmo == TMO_LAST) begin
          w_next = S_TRAP;
        end
      end
      S_WRITEBACK: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
        w_retire  = 1'b1;
        if (r_opq == OP_LOAD) begin
          wb_sel = 2'b01;
        end else if (r_opq == OP_JAL || r_opq == OP_JALR) begin
          // Operands repeat the EXECUTE selection so the jump target stays stable
          wb_sel    = 2'b10;
          pc_write  = 1'b1;
          pc_sel    = 1'b1;
          alu_src_a = (r_opq == OP_JAL);
          alu_src_b = 1'b1;
        end
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  assign state   = r_state;
  assign illegal = (r_state == S_TRAP);
  assign retired = r_ret;

endmodule
